// File: rtl/axi4_port_arbiter_if.sv
// Bundled upstream (s_*) and downstream (m_*) AXI4 channels for the port arbiter.
// Upstream buses are flattened per port: port k occupies slice [k*W +: W].
// The "master" modport is the arbiter's view: it is the AXI master towards the
// interconnect and the slave towards the core's memory masters.
// The "slave" modport is the mirror view used by whatever surrounds the arbiter.
interface axi4_port_arbiter_if #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
);
    localparam int STRB_W = DATA_W / 8;

    // upstream read address / data
    logic [N_PORTS-1:0]        s_arvalid;
    logic [N_PORTS-1:0]        s_arready;
    logic [N_PORTS*ADDR_W-1:0] s_araddr;
    logic [N_PORTS*ID_W-1:0]   s_arid;
    logic [N_PORTS*3-1:0]      s_arsize;
    logic [N_PORTS*8-1:0]      s_arlen;
    logic [N_PORTS*2-1:0]      s_arburst;
    logic [N_PORTS-1:0]        s_arlock;
    logic [N_PORTS*4-1:0]      s_arcache;
    logic [N_PORTS*3-1:0]      s_arprot;
    logic [N_PORTS-1:0]        s_rvalid;
    logic [N_PORTS-1:0]        s_rready;
    logic [DATA_W-1:0]         s_rdata;
    logic [ID_W-1:0]           s_rid;
    logic                      s_rlast;
    logic [1:0]                s_rresp;

    // upstream write address / data / response
    logic [N_PORTS-1:0]        s_awvalid;
    logic [N_PORTS-1:0]        s_awready;
    logic [N_PORTS*ADDR_W-1:0] s_awaddr;
    logic [N_PORTS*ID_W-1:0]   s_awid;
    logic [N_PORTS*3-1:0]      s_awsize;
    logic [N_PORTS*8-1:0]      s_awlen;
    logic [N_PORTS*2-1:0]      s_awburst;
    logic [N_PORTS-1:0]        s_awlock;
    logic [N_PORTS*4-1:0]      s_awcache;
    logic [N_PORTS*3-1:0]      s_awprot;
    logic [N_PORTS-1:0]        s_wvalid;
    logic [N_PORTS-1:0]        s_wready;
    logic [N_PORTS*DATA_W-1:0] s_wdata;
    logic [N_PORTS*ID_W-1:0]   s_wid;
    logic [N_PORTS-1:0]        s_wlast;
    logic [N_PORTS*STRB_W-1:0] s_wstrb;
    logic [N_PORTS-1:0]        s_bvalid;
    logic [N_PORTS-1:0]        s_bready;
    logic [ID_W-1:0]           s_bid;
    logic [1:0]                s_bresp;

    // downstream single port
    logic                      m_arvalid;
    logic                      m_arready;
    logic [ADDR_W-1:0]         m_araddr;
    logic [ID_W-1:0]           m_arid;
    logic [2:0]                m_arsize;
    logic [7:0]                m_arlen;
    logic [1:0]                m_arburst;
    logic                      m_arlock;
    logic [3:0]                m_arcache;
    logic [2:0]                m_arprot;
    logic                      m_rvalid;
    logic                      m_rready;
    logic [DATA_W-1:0]         m_rdata;
    logic [ID_W-1:0]           m_rid;
    logic                      m_rlast;
    logic [1:0]                m_rresp;
    logic                      m_awvalid;
    logic                      m_awready;
    logic [ADDR_W-1:0]         m_awaddr;
    logic [ID_W-1:0]           m_awid;
    logic [2:0]                m_awsize;
    logic [7:0]                m_awlen;
    logic [1:0]                m_awburst;
    logic                      m_awlock;
    logic [3:0]                m_awcache;
    logic [2:0]                m_awprot;
    logic                      m_wvalid;
    logic                      m_wready;
    logic [DATA_W-1:0]         m_wdata;
    logic [ID_W-1:0]           m_wid;
    logic                      m_wlast;
    logic [STRB_W-1:0]         m_wstrb;
    logic                      m_bvalid;
    logic                      m_bready;
    logic [ID_W-1:0]           m_bid;
    logic [1:0]                m_bresp;

    modport master (
        input  s_arvalid, s_araddr, s_arid, s_arsize, s_arlen, s_arburst,
               s_arlock, s_arcache, s_arprot, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rid, s_rlast, s_rresp,
        input  s_awvalid, s_awaddr, s_awid, s_awsize, s_awlen, s_awburst,
               s_awlock, s_awcache, s_awprot,
        input  s_wvalid, s_wdata, s_wid, s_wlast, s_wstrb, s_bready,
        output s_awready, s_wready, s_bvalid, s_bid, s_bresp,
        output m_arvalid, m_araddr, m_arid, m_arsize, m_arlen, m_arburst,
               m_arlock, m_arcache, m_arprot, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rid, m_rlast, m_rresp,
        output m_awvalid, m_awaddr, m_awid, m_awsize, m_awlen, m_awburst,
               m_awlock, m_awcache, m_awprot,
        output m_wvalid, m_wdata, m_wid, m_wlast, m_wstrb, m_bready,
        input  m_awready, m_wready, m_bvalid, m_bid, m_bresp
    );

    modport slave (
        output s_arvalid, s_araddr, s_arid, s_arsize, s_arlen, s_arburst,
               s_arlock, s_arcache, s_arprot, s_rready,
        input  s_arready, s_rvalid, s_rdata, s_rid, s_rlast, s_rresp,
        output s_awvalid, s_awaddr, s_awid, s_awsize, s_awlen, s_awburst,
               s_awlock, s_awcache, s_awprot,
        output s_wvalid, s_wdata, s_wid, s_wlast, s_wstrb, s_bready,
        input  s_awready, s_wready, s_bvalid, s_bid, s_bresp,
        input  m_arvalid, m_araddr, m_arid, m_arsize, m_arlen, m_arburst,
               m_arlock, m_arcache, m_arprot, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rid, m_rlast, m_rresp,
        input  m_awvalid, m_awaddr, m_awid, m_awsize, m_awlen, m_awburst,
               m_awlock, m_awcache, m_awprot,
        input  m_wvalid, m_wdata, m_wid, m_wlast, m_wstrb, m_bready,
        output m_awready, m_wready, m_bvalid, m_bid, m_bresp
    );
endinterface

// File: rtl/axi4_port_arbiter.sv
// N-to-1 AXI4 master-port arbiter. Read and write paths each hold one
// transaction at a time, chosen round-robin, and keep the grant until the
// final R beat (reads) or the B response (writes).
//
// state  | meaning
// -------+--------------------------------------------------------------
// R_IDLE | no read granted; pick next requester from rr_ptr
// R_ADDR | forwarding AR of port rg downstream
// R_DATA | steering R beats to port rg until the rlast handshake
// W_IDLE | no write granted; pick next AW requester from wr_ptr
// W_ADDR | forwarding AW of port wg; its W beats are still stalled
// W_DATA | forwarding W beats of port wg until the wlast handshake
// W_RESP | steering the B response to port wg
module axi4_port_arbiter #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    axi4_port_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t        rd_state, rd_state_nxt;
    wr_state_t        wr_state, wr_state_nxt;
    logic [PTR_W-1:0] rg, rg_nxt, rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0] wg, wg_nxt, wr_ptr, wr_ptr_nxt;

    // First requesting port at or after ptr, searching cyclically.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               j;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            j = (int'(ptr) + i) % N_PORTS;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PTR_W'(j);
            end
        end
        return pick;
    endfunction

    // Pointer moves past the port just served, wrapping at N_PORTS.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Shared response payloads follow the downstream side; only valids are steered.
    assign bus.s_rdata = bus.m_rdata;
    assign bus.s_rid   = bus.m_rid;
    assign bus.s_rlast = bus.m_rlast;
    assign bus.s_rresp = bus.m_rresp;
    assign bus.s_bid   = bus.m_bid;
    assign bus.s_bresp = bus.m_bresp;

    // Read path state, grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rg       <= '0;
            rr_ptr   <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            rg       <= rg_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    // Read path next state and channel steering.
    always_comb begin
        rd_state_nxt  = rd_state;
        rg_nxt        = rg;
        rr_ptr_nxt    = rr_ptr;
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arid    = '0;
        bus.m_arsize  = '0;
        bus.m_arlen   = '0;
        bus.m_arburst = '0;
        bus.m_arlock  = 1'b0;
        bus.m_arcache = '0;
        bus.m_arprot  = '0;
        bus.m_rready  = 1'b0;
        bus.s_arready = '0;
        bus.s_rvalid  = '0;
        case (rd_state)
            R_IDLE: begin
                if (|bus.s_arvalid) begin
                    rg_nxt       = rr_pick(bus.s_arvalid, rr_ptr);
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                bus.m_arvalid     = bus.s_arvalid[rg];
                bus.m_araddr      = bus.s_araddr[int'(rg)*ADDR_W +: ADDR_W];
                bus.m_arid        = bus.s_arid[int'(rg)*ID_W +: ID_W];
                bus.m_arsize      = bus.s_arsize[int'(rg)*3 +: 3];
                bus.m_arlen       = bus.s_arlen[int'(rg)*8 +: 8];
                bus.m_arburst     = bus.s_arburst[int'(rg)*2 +: 2];
                bus.m_arlock      = bus.s_arlock[rg];
                bus.m_arcache     = bus.s_arcache[int'(rg)*4 +: 4];
                bus.m_arprot      = bus.s_arprot[int'(rg)*3 +: 3];
                bus.s_arready[rg] = bus.m_arready;
                if (bus.s_arvalid[rg] && bus.m_arready) begin
                    rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                bus.s_rvalid[rg] = bus.m_rvalid;
                bus.m_rready     = bus.s_rready[rg];
                if (bus.m_rvalid && bus.s_rready[rg] && bus.m_rlast) begin
                    rd_state_nxt = R_IDLE;
                    rr_ptr_nxt   = ptr_next(rg);
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Write path state, grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wg       <= '0;
            wr_ptr   <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wg       <= wg_nxt;
            wr_ptr   <= wr_ptr_nxt;
        end
    end

    // Write path next state and channel steering; W stays stalled until AW is accepted.
    always_comb begin
        wr_state_nxt  = wr_state;
        wg_nxt        = wg;
        wr_ptr_nxt    = wr_ptr;
        bus.m_awvalid = 1'b0;
        bus.m_awaddr  = '0;
        bus.m_awid    = '0;
        bus.m_awsize  = '0;
        bus.m_awlen   = '0;
        bus.m_awburst = '0;
        bus.m_awlock  = 1'b0;
        bus.m_awcache = '0;
        bus.m_awprot  = '0;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wid     = '0;
        bus.m_wlast   = 1'b0;
        bus.m_wstrb   = '0;
        bus.m_bready  = 1'b0;
        bus.s_awready = '0;
        bus.s_wready  = '0;
        bus.s_bvalid  = '0;
        case (wr_state)
            W_IDLE: begin
                if (|bus.s_awvalid) begin
                    wg_nxt       = rr_pick(bus.s_awvalid, wr_ptr);
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                bus.m_awvalid     = bus.s_awvalid[wg];
                bus.m_awaddr      = bus.s_awaddr[int'(wg)*ADDR_W +: ADDR_W];
                bus.m_awid        = bus.s_awid[int'(wg)*ID_W +: ID_W];
                bus.m_awsize      = bus.s_awsize[int'(wg)*3 +: 3];
                bus.m_awlen       = bus.s_awlen[int'(wg)*8 +: 8];
                bus.m_awburst     = bus.s_awburst[int'(wg)*2 +: 2];
                bus.m_awlock      = bus.s_awlock[wg];
                bus.m_awcache     = bus.s_awcache[int'(wg)*4 +: 4];
                bus.m_awprot      = bus.s_awprot[int'(wg)*3 +: 3];
                bus.s_awready[wg] = bus.m_awready;
                if (bus.s_awvalid[wg] && bus.m_awready) begin
                    wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                bus.m_wvalid     = bus.s_wvalid[wg];
                bus.m_wdata      = bus.s_wdata[int'(wg)*DATA_W +: DATA_W];
                bus.m_wid        = bus.s_wid[int'(wg)*ID_W +: ID_W];
                bus.m_wlast      = bus.s_wlast[wg];
                bus.m_wstrb      = bus.s_wstrb[int'(wg)*STRB_W +: STRB_W];
                bus.s_wready[wg] = bus.m_wready;
                if (bus.s_wvalid[wg] && bus.m_wready && bus.s_wlast[wg]) begin
                    wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bus.s_bvalid[wg] = bus.m_bvalid;
                bus.m_bready     = bus.s_bready[wg];
                if (bus.m_bvalid && bus.s_bready[wg]) begin
                    wr_state_nxt = W_IDLE;
                    wr_ptr_nxt   = ptr_next(wg);
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_port_arbiter.sv
// Directed and randomized bench for axi4_port_arbiter. A small behavioural
// model tracks the round-robin pointers as integers and predicts each grant.
module tb_axi4_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_port_arbiter_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();
    axi4_port_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int rr_model = 0;
    int wr_model = 0;

    logic [AW-1:0] ar_addr [N];
    logic [7:0]    ar_len  [N];
    logic [IW-1:0] ar_id   [N];
    logic [2:0]    ar_prot [N];
    logic [AW-1:0] aw_addr [N];
    logic [7:0]    aw_len  [N];
    logic [IW-1:0] aw_id   [N];
    logic [2:0]    aw_prot [N];
    logic [DW-1:0] w_data  [N];
    logic [SW-1:0] w_strb  [N];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        return N'(1) << k;
    endfunction

    task automatic issue_ar(input int k, input bit fixed);
        ar_addr[k] = fixed ? 32'h0000_1000 : AW'($urandom);
        ar_len[k]  = fixed ? 8'd3 : 8'($urandom_range(0, 3));
        ar_id[k]   = IW'($urandom);
        ar_prot[k] = 3'($urandom);
        bus.s_araddr[k*AW +: AW] = ar_addr[k];
        bus.s_arlen[k*8 +: 8]    = ar_len[k];
        bus.s_arid[k*IW +: IW]   = ar_id[k];
        bus.s_arprot[k*3 +: 3]   = ar_prot[k];
        bus.s_arsize[k*3 +: 3]   = 3'd2;
        bus.s_arburst[k*2 +: 2]  = 2'b01;
        bus.s_arcache[k*4 +: 4]  = 4'($urandom);
        bus.s_arlock[k]          = 1'b0;
        bus.s_arvalid[k]         = 1'b1;
    endtask

    task automatic read_round(input logic [N-1:0] mask, input int n, input bit cont,
                              input bit fixed, input int stall);
        logic [N-1:0]  req;
        int            exp, lat, d, l;
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        req = mask;
        for (int k = 0; k < N; k++) if (mask[k]) issue_ar(k, fixed);
        for (int g = 0; g < n; g++) begin
            exp = pick(req, rr_model);
            if (exp < 0) break;
            lat = 0;
            do begin
                tick(); #1; lat++;
            end while (!bus.m_arvalid && lat < 8);
            chk("ar_latency", lat, 1);
            if (!bus.m_arvalid) return;
            chk("ar_addr", bus.m_araddr, ar_addr[exp]);
            chk("ar_len", bus.m_arlen, ar_len[exp]);
            chk("ar_id", bus.m_arid, ar_id[exp]);
            chk("ar_prot", bus.m_arprot, ar_prot[exp]);
            d = (stall >= 0) ? stall : $urandom_range(0, 2);
            for (int s = 0; s < d; s++) begin
                bus.m_arready = 1'b0; #1;
                chk("ar_stall_ready", bus.s_arready, 0);
                tick(); #1;
                chk("ar_hold_valid", bus.m_arvalid, 1);
            end
            bus.m_arready = 1'b1; #1;
            chk("ar_ready_steer", bus.s_arready, onehot(exp));
            tick();
            bus.m_arready = 1'b0;
            l = ar_len[exp];
            if (cont) issue_ar(exp, 1'b0);
            else begin
                bus.s_arvalid[exp] = 1'b0;
                req[exp] = 1'b0;
            end
            for (int b = 0; b <= l; b++) begin
                if (stall < 0 && $urandom_range(0, 3) == 0) begin
                    bus.m_rvalid = 1'b0;
                    bus.s_rready = N'($urandom);
                    #1;
                    chk("r_gap_valid", bus.s_rvalid, 0);
                    chk("r_no_ar", bus.m_arvalid, 0);
                    tick();
                end
                rd = DW'($urandom);
                rr = 2'($urandom);
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = rd;
                bus.m_rresp  = rr;
                bus.m_rid    = ar_id[exp];
                bus.m_rlast  = (b == l);
                d = (stall >= 0) ? stall : $urandom_range(0, 2);
                for (int s = 0; s < d; s++) begin
                    bus.s_rready = N'($urandom) & ~onehot(exp); #1;
                    chk("r_bp_ready", bus.m_rready, 0);
                    chk("r_bp_steer", bus.s_rvalid, onehot(exp));
                    tick();
                end
                bus.s_rready = N'($urandom) | onehot(exp); #1;
                chk("r_ready", bus.m_rready, 1);
                chk("r_valid_steer", bus.s_rvalid, onehot(exp));
                chk("r_data", bus.s_rdata, rd);
                chk("r_resp", bus.s_rresp, rr);
                chk("r_last", bus.s_rlast, (b == l));
                chk("r_no_arready", bus.s_arready, 0);
                tick();
            end
            bus.m_rvalid = 1'b0;
            bus.m_rlast  = 1'b0;
            bus.s_rready = '0;
            rr_model = (exp + 1) % N;
        end
        bus.s_arvalid = '0;
    endtask

    task automatic issue_w(input int k, input bit fixed);
        aw_addr[k] = AW'($urandom);
        aw_len[k]  = fixed ? 8'd1 : 8'($urandom_range(0, 3));
        aw_id[k]   = IW'($urandom);
        aw_prot[k] = 3'($urandom);
        w_data[k]  = fixed ? 32'hDEAD_BEEF : DW'($urandom);
        w_strb[k]  = fixed ? 4'hF : SW'($urandom);
        bus.s_wdata[k*DW +: DW] = w_data[k];
        bus.s_wstrb[k*SW +: SW] = w_strb[k];
        bus.s_wid[k*IW +: IW]   = aw_id[k];
        bus.s_wlast[k]          = (aw_len[k] == 8'd0);
        bus.s_wvalid[k]         = 1'b1;
    endtask

    task automatic issue_aw(input int k);
        bus.s_awaddr[k*AW +: AW] = aw_addr[k];
        bus.s_awlen[k*8 +: 8]    = aw_len[k];
        bus.s_awid[k*IW +: IW]   = aw_id[k];
        bus.s_awprot[k*3 +: 3]   = aw_prot[k];
        bus.s_awsize[k*3 +: 3]   = 3'd2;
        bus.s_awburst[k*2 +: 2]  = 2'b01;
        bus.s_awcache[k*4 +: 4]  = 4'($urandom);
        bus.s_awlock[k]          = 1'b0;
        bus.s_awvalid[k]         = 1'b1;
    endtask

    task automatic write_round(input logic [N-1:0] mask, input int n, input bit cont,
                               input bit fixed, input int early, input int stall);
        logic [N-1:0] req;
        int           exp, lat, d, l;
        logic [IW-1:0] bid;
        logic [1:0]    br;
        req = mask;
        for (int k = 0; k < N; k++) if (mask[k]) issue_w(k, fixed);
        for (int e = 0; e < early; e++) begin
            bus.m_wready = 1'b1; #1;
            chk("w_early_stall", bus.s_wready, 0);
            chk("w_early_fwd", bus.m_wvalid, 0);
            tick();
        end
        bus.m_wready = 1'b0;
        for (int k = 0; k < N; k++) if (mask[k]) issue_aw(k);
        for (int g = 0; g < n; g++) begin
            exp = pick(req, wr_model);
            if (exp < 0) break;
            lat = 0;
            do begin
                tick(); #1; lat++;
            end while (!bus.m_awvalid && lat < 8);
            chk("aw_latency", lat, 1);
            if (!bus.m_awvalid) return;
            chk("aw_addr", bus.m_awaddr, aw_addr[exp]);
            chk("aw_len", bus.m_awlen, aw_len[exp]);
            chk("aw_id", bus.m_awid, aw_id[exp]);
            chk("aw_prot", bus.m_awprot, aw_prot[exp]);
            d = (stall >= 0) ? stall : $urandom_range(0, 2);
            for (int s = 0; s < d; s++) begin
                bus.m_awready = 1'b0;
                bus.m_wready  = 1'b1; #1;
                chk("aw_stall_ready", bus.s_awready, 0);
                chk("w_before_aw", bus.s_wready, 0);
                tick();
            end
            bus.m_wready  = 1'b0;
            bus.m_awready = 1'b1; #1;
            chk("aw_ready_steer", bus.s_awready, onehot(exp));
            tick();
            bus.m_awready = 1'b0;
            bus.s_awvalid[exp] = 1'b0;
            l = aw_len[exp];
            for (int b = 0; b <= l; b++) begin
                d = (stall >= 0) ? stall : $urandom_range(0, 2);
                for (int s = 0; s < d; s++) begin
                    bus.m_wready = 1'b0; #1;
                    chk("w_bp_valid", bus.m_wvalid, 1);
                    chk("w_bp_ready", bus.s_wready, 0);
                    tick();
                end
                bus.m_wready = 1'b1; #1;
                chk("w_ready_steer", bus.s_wready, onehot(exp));
                chk("w_data", bus.m_wdata, w_data[exp]);
                chk("w_strb", bus.m_wstrb, w_strb[exp]);
                chk("w_last", bus.m_wlast, (b == l));
                chk("w_id", bus.m_wid, aw_id[exp]);
                tick();
                bus.m_wready = 1'b0;
                if (b < l) begin
                    w_data[exp] = fixed ? 32'hCAFE_F00D : DW'($urandom);
                    bus.s_wdata[exp*DW +: DW] = w_data[exp];
                    bus.s_wlast[exp] = (b + 1 == l);
                end
            end
            bus.s_wvalid[exp] = 1'b0;
            bus.s_wlast[exp]  = 1'b0;
            if (cont) begin
                issue_w(exp, 1'b0);
                issue_aw(exp);
            end else begin
                req[exp] = 1'b0;
            end
            bid = IW'($urandom);
            br  = 2'($urandom);
            bus.m_bvalid = 1'b1;
            bus.m_bid    = bid;
            bus.m_bresp  = br;
            d = (stall >= 0) ? stall : $urandom_range(0, 2);
            for (int s = 0; s < d; s++) begin
                bus.s_bready = N'($urandom) & ~onehot(exp); #1;
                chk("b_bp_ready", bus.m_bready, 0);
                chk("b_bp_steer", bus.s_bvalid, onehot(exp));
                chk("b_w_stall", bus.s_wready, 0);
                tick();
            end
            bus.s_bready = N'($urandom) | onehot(exp); #1;
            chk("b_ready", bus.m_bready, 1);
            chk("b_valid_steer", bus.s_bvalid, onehot(exp));
            chk("b_id", bus.s_bid, bid);
            chk("b_resp", bus.s_bresp, br);
            tick();
            bus.m_bvalid = 1'b0;
            bus.s_bready = '0;
            wr_model = (exp + 1) % N;
        end
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.s_wlast   = '0;
    endtask

    task automatic clear_inputs();
        bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arid = '0; bus.s_arsize = '0;
        bus.s_arlen = '0; bus.s_arburst = '0; bus.s_arlock = '0; bus.s_arcache = '0;
        bus.s_arprot = '0; bus.s_rready = '0;
        bus.s_awvalid = '0; bus.s_awaddr = '0; bus.s_awid = '0; bus.s_awsize = '0;
        bus.s_awlen = '0; bus.s_awburst = '0; bus.s_awlock = '0; bus.s_awcache = '0;
        bus.s_awprot = '0; bus.s_wvalid = '0; bus.s_wdata = '0; bus.s_wid = '0;
        bus.s_wlast = '0; bus.s_wstrb = '0; bus.s_bready = '0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rid = '0;
        bus.m_rlast = 1'b0; bus.m_rresp = '0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_bid = '0; bus.m_bresp = '0;
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_m_arvalid"}, bus.m_arvalid, 0);
        chk({tag, "_m_araddr"}, bus.m_araddr, 0);
        chk({tag, "_m_rready"}, bus.m_rready, 0);
        chk({tag, "_s_arready"}, bus.s_arready, 0);
        chk({tag, "_s_rvalid"}, bus.s_rvalid, 0);
        chk({tag, "_m_awvalid"}, bus.m_awvalid, 0);
        chk({tag, "_m_awaddr"}, bus.m_awaddr, 0);
        chk({tag, "_s_awready"}, bus.s_awready, 0);
        chk({tag, "_m_wvalid"}, bus.m_wvalid, 0);
        chk({tag, "_s_wready"}, bus.s_wready, 0);
        chk({tag, "_m_bready"}, bus.m_bready, 0);
        chk({tag, "_s_bvalid"}, bus.s_bvalid, 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        // Requests and payloads present during reset must not leak out.
        bus.s_arvalid = '1;
        bus.s_araddr  = {N{32'hA5A5_0F0F}};
        bus.s_awvalid = '1;
        bus.s_awaddr  = {N{32'h5A5A_F0F0}};
        bus.s_wvalid  = '1;
        bus.m_wready  = 1'b1;
        bus.m_rvalid  = 1'b1;
        bus.s_rready  = '1;
        tick(); tick(); #1;
        chk_all_idle("reset");
        clear_inputs();
        rst = 1'b0;
        rr_model = 0;
        wr_model = 0;

        // Contention from reset, all ports requesting continuously: 0,1,2,0.
        read_round(3'b111, 4, 1'b1, 1'b0, -1);
        // Single read on port 1: addr 0x1000, len 3.
        read_round(3'b010, 1, 1'b0, 1'b1, -1);
        // Concurrent read on port 0 and write on port 2 with fixed data.
        fork
            read_round(3'b001, 1, 1'b0, 1'b0, -1);
            write_round(3'b100, 1, 1'b0, 1'b1, 0, -1);
        join
        // Early W on port 1: three cycles of W before its AW.
        write_round(3'b010, 1, 1'b0, 1'b0, 3, -1);
        // Backpressure: five-cycle stalls on every handshake.
        read_round(3'b011, 2, 1'b0, 1'b0, 5);
        write_round(3'b101, 2, 1'b0, 1'b0, 0, 5);
        // Write contention with continuous requesters.
        write_round(3'b111, 4, 1'b1, 1'b0, 0, -1);
        // Randomized concurrent rounds.
        for (int r = 0; r < 8; r++) begin
            fork
                read_round(N'($urandom_range(1, 7)), $urandom_range(1, 4), 1'($urandom), 1'b0, -1);
                write_round(N'($urandom_range(1, 7)), $urandom_range(1, 4), 1'($urandom), 1'b0,
                            $urandom_range(0, 1), -1);
            join
        end

        // Park both pointers at 2, then reset during beat 2 of a 4-beat read on port 2.
        read_round(3'b010, 1, 1'b0, 1'b0, -1);
        write_round(3'b010, 1, 1'b0, 1'b0, 0, -1);
        issue_ar(2, 1'b1);
        issue_w(0, 1'b0);
        issue_aw(0);
        tick(); #1;
        chk("rst_ar_granted", bus.m_arvalid, 1);
        bus.m_arready = 1'b1;
        tick();
        bus.m_arready = 1'b0;
        bus.s_arvalid = '0;
        for (int b = 0; b < 2; b++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = DW'($urandom);
            bus.s_rready = 3'b100;
            #1;
            chk("rst_pre_beat", bus.s_rvalid, 3'b100);
            tick();
        end
        bus.m_rvalid = 1'b1;
        bus.s_rready = '1;
        rst = 1'b1;
        tick(); #1;
        chk_all_idle("midrst");
        clear_inputs();
        rst = 1'b0;
        rr_model = 0;
        wr_model = 0;
        // Pointers back at 0: ports 1 and 2 requesting must grant port 1 first.
        read_round(3'b110, 2, 1'b0, 1'b0, -1);
        write_round(3'b110, 2, 1'b0, 1'b0, 0, -1);
        tick(); #1;
        chk_all_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
